// File: rtl/adc_tone_meter.sv
// Tone period and peak-to-peak meter for an offset-binary ADC stream.
// Optional TONE_METER_AVG_EN: report the average of 4 periods and the largest pk2pk of those 4.
module adc_tone_meter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16,
    parameter int          HYST   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    output logic [CNT_W-1:0]  period,
    output logic [DATA_W:0]   pk2pk,
    output logic              meas_valid,
    output logic              timeout,
    output logic              locked
);

    localparam logic signed [DATA_W-1:0] HYST_P  = DATA_W'(HYST);
    localparam logic signed [DATA_W-1:0] HYST_N  = DATA_W'(-HYST);
    localparam logic        [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {S_INIT, S_LOW, S_HIGH} state_t;

    state_t                    state_q, state_d;
    logic                      armed_q;
    logic        [CNT_W-1:0]   cnt_q;
    logic signed [DATA_W-1:0]  min_q, max_q;

    logic signed [DATA_W-1:0]  smp_c;
    logic signed [DATA_W-1:0]  min_new_c, max_new_c;
    logic        [CNT_W-1:0]   cnt_inc_c;
    logic        [DATA_W:0]    pk_c;
    logic                      rise_c;
    logic                      tmo_c;

`ifdef TONE_METER_AVG_EN
    logic [CNT_W+1:0] acc_q;
    logic [1:0]       idx_q;
    logic [DATA_W:0]  pkm_q;
    logic [CNT_W+1:0] acc_sum_c;
    logic [DATA_W:0]  pkm_new_c;

    assign acc_sum_c = acc_q + (CNT_W+2)'(cnt_inc_c);
    assign pkm_new_c = (pk_c > pkm_q) ? pk_c : pkm_q;
`endif

    // Flipping the MSB turns offset-binary into two's complement.
    assign smp_c     = {~adc_data[DATA_W-1], adc_data[DATA_W-2:0]};
    assign min_new_c = (smp_c < min_q) ? smp_c : min_q;
    assign max_new_c = (smp_c > max_q) ? smp_c : max_q;
    assign cnt_inc_c = cnt_q + CNT_W'(1);
    // Sign-extended difference cannot overflow and is never negative.
    assign pk_c      = {max_new_c[DATA_W-1], max_new_c} - {min_new_c[DATA_W-1], min_new_c};

    // Schmitt-trigger crossing FSM; a timeout forces re-acquisition.
    always_comb begin
        state_d = state_q;
        rise_c  = 1'b0;
        tmo_c   = 1'b0;
        if (adc_valid) begin
            case (state_q)
                S_INIT:  if (smp_c <= HYST_N) state_d = S_LOW;
                S_LOW: begin
                    if (smp_c >= HYST_P) begin
                        state_d = S_HIGH;
                        rise_c  = 1'b1;
                    end
                end
                S_HIGH:  if (smp_c <= HYST_N) state_d = S_LOW;
                default: state_d = S_INIT;
            endcase
            if (armed_q && !rise_c && cnt_inc_c == CNT_MAX) begin
                tmo_c   = 1'b1;
                state_d = S_INIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT;
            armed_q    <= 1'b0;
            cnt_q      <= '0;
            min_q      <= '0;
            max_q      <= '0;
            period     <= '0;
            pk2pk      <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            locked     <= 1'b0;
`ifdef TONE_METER_AVG_EN
            acc_q      <= '0;
            idx_q      <= '0;
            pkm_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            if (adc_valid) begin
                if (tmo_c) begin
                    armed_q <= 1'b0;
                    locked  <= 1'b0;
                    timeout <= 1'b1;
`ifdef TONE_METER_AVG_EN
                    acc_q   <= '0;
                    idx_q   <= '0;
                    pkm_q   <= '0;
`endif
                end else if (rise_c) begin
                    armed_q <= 1'b1;
                    cnt_q   <= '0;
                    min_q   <= smp_c;
                    max_q   <= smp_c;
                    if (armed_q) begin
`ifdef TONE_METER_AVG_EN
                        if (idx_q == 2'd3) begin
                            period     <= acc_sum_c[CNT_W+1:2];
                            pk2pk      <= pkm_new_c;
                            meas_valid <= 1'b1;
                            locked     <= 1'b1;
                            acc_q      <= '0;
                            pkm_q      <= '0;
                            idx_q      <= '0;
                        end else begin
                            acc_q <= acc_sum_c;
                            pkm_q <= pkm_new_c;
                            idx_q <= idx_q + 2'd1;
                        end
`else
                        period     <= cnt_inc_c;
                        pk2pk      <= pk_c;
                        meas_valid <= 1'b1;
                        locked     <= 1'b1;
`endif
                    end
                end else if (armed_q) begin
                    cnt_q <= cnt_inc_c;
                    min_q <= min_new_c;
                    max_q <= max_new_c;
                end
            end
        end
    end

endmodule

// File: doc/adc_tone_meter.md
ADC_TONE_METER -- requirements
Module: adc_tone_meter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the ADC sample width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the period counter and period output.
REQ-003 The block SHALL have parameter HYST, default 8, meaning the zero-crossing hysteresis threshold in signed LSBs.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port adc_data, input, DATA_W bits: ADC sample in offset-binary (mid-code = 2^(DATA_W-1)).
REQ-007 The block SHALL have port adc_valid, input, 1 bit: adc_data is sampled on a clk edge where adc_valid=1.
REQ-008 The block SHALL have port period, output, CNT_W bits: measured tone period in valid samples.
REQ-009 The block SHALL have port pk2pk, output, DATA_W+1 bits: unsigned peak-to-peak amplitude over the measured period.
REQ-010 The block SHALL have port meas_valid, output, 1 bit: one-cycle pulse when period and pk2pk update.
REQ-011 The block SHALL have port timeout, output, 1 bit: one-cycle pulse when no crossing is seen within the counter range.
REQ-012 The block SHALL have port locked, output, 1 bit: level, high after the first complete measurement, cleared on timeout.

Function
REQ-013 Each valid sample SHALL be converted to signed two's complement by inverting its MSB.
REQ-014 The crossing FSM SHALL have states S_INIT, S_LOW and S_HIGH, and SHALL change state only on valid samples.
REQ-015 S_INIT SHALL go to S_LOW when the signed sample <= -HYST, and SHALL otherwise remain in S_INIT.
REQ-016 S_LOW SHALL go to S_HIGH when the signed sample >= +HYST; this transition is a rising crossing.
REQ-017 S_HIGH SHALL go to S_LOW when the signed sample <= -HYST; samples strictly inside the hysteresis band SHALL hold the current state.
REQ-018 The first rising crossing after S_INIT SHALL arm the meter without producing an output, and SHALL set the counter to 0 and min/max to the crossing sample.
REQ-019 While armed, each valid sample SHALL increment the counter and update the running min/max of signed samples.
REQ-020 On each armed rising crossing, period SHALL equal the sample count since the previous crossing, with the current sample included and the previous crossing sample excluded.
REQ-021 On each armed rising crossing, pk2pk SHALL equal max-min including the current sample, computed at DATA_W+1 bits without overflow.
REQ-022 After each armed rising crossing, the counter SHALL restart and min/max SHALL re-seed to the crossing sample.
REQ-023 meas_valid SHALL pulse exactly one clk cycle after the edge that sampled the crossing; period and pk2pk SHALL be registered and held until the next update.
REQ-024 If the counter reaches 2^CNT_W-1 while armed, the block SHALL pulse timeout for one cycle on the next clk, go to S_INIT, disarm, clear locked, and leave period/pk2pk unchanged.
REQ-025 locked SHALL set together with the first meas_valid pulse.
REQ-026 The block SHALL hold all state and output no pulses on cycles with adc_valid=0.

Reset
REQ-027 When rst=1 at a clk edge, the block SHALL go to S_INIT and disarm, and SHALL set period=0, pk2pk=0, meas_valid=0, timeout=0 and locked=0.
REQ-028 rst SHALL take priority over adc_valid; a measurement in progress SHALL be discarded and the next crossing SHALL only re-arm.

Configuration
REQ-029 With macro TONE_METER_AVG_EN defined, the block SHALL accumulate 4 consecutive periods in CNT_W+2 bits and output their sum>>2, asserting meas_valid once per 4 crossings with pk2pk as the maximum of the 4.
REQ-030 Without TONE_METER_AVG_EN, the block SHALL report every period individually as specified in REQ-020 to REQ-023.
REQ-031 With TONE_METER_AVG_EN defined, timeout or reset SHALL clear the averaging accumulator and its 0..3 index.

Verification
REQ-032 Full-scale 72-sample cosine, adc_valid=1 continuously -> first meas_valid after 2nd rising crossing, period=72, pk2pk=254 (+/-2), locked=1.
REQ-033 Same tone with adc_valid toggled 1/0 alternately -> period=72, and meas_valid spacing = 144 clks.
REQ-034 Constant mid-code (0x80) for 70000 samples after lock -> one timeout pulse, locked=0, period keeps 72.
REQ-035 Sine amplitude +/-5 LSB (inside HYST=8) -> FSM stays S_INIT, no meas_valid, no timeout.
REQ-036 rst=1 for one cycle mid-period -> all outputs 0 next cycle; the next measurement needs 2 crossings after reset.
REQ-037 With TONE_METER_AVG_EN: alternating periods 70 and 74 -> meas_valid every 4 crossings, period=72.
